irq_ctr_gen: RTL and testbench
==============================

Name: irq_ctr_gen

Overview:
- Parametrised successor to the fixed 8-bit MMC3 scanline IRQ counter, used inside mapper modules.
- Fully synchronous to `clk`. It samples `m2` and PPU A12 through synchronisers instead of clocking on them.
- Selectable modes: MMC3 new-style, MMC3A old-style, and CPU-cycle down-counter.
- Counter width and A12 filter length are configurable. Save-state access is available as an option.

Parameters:
- CTR_W, 8, counter/latch width in bits (8..16).
- SYNC_ST, 2, synchroniser flop stages on `m2` and `ppu_a12`.
- A12_FILT, 3, minimum count of M2 falling edges with A12 low before an A12 rise counts as a clock.

Ports:
- clk  in  1  system clock.
- map_rst  in  1  reset, asynchronous, active-high.
- m2  in  1  CPU M2, asynchronous to clk.
- ppu_a12  in  1  PPU address bit 12, asynchronous to clk.
- mode  in  2  0=MMC3, 1=MMC3A, 2=CPU-cycle, 3=reserved (counter frozen).
- reg_we  in  1  one-clk register write strobe.
- reg_sel  in  3  register select.
- reg_dat  in  8  write data.
- ss_act  in  1  save-state session active; freezes counting.
- ss_we  in  1  save-state write strobe (one clk).
- ss_addr  in  8  save-state address.
- ss_din  in  8  save-state write data.
- ss_dout  out  8  save-state read data.
- irq  out  1  IRQ pending, active-high.

Behaviour:
- Reset (async, map_rst=1): ctr, latch, en, pend, reload_req all 0; irq=0; ss_dout=8'hff. Filter history cleared, treated as A12 low for A12_FILT edges. Deassertion is synchronised internally.
- Registers, write on reg_we:
  - 0: latch[7:0].
  - 1: latch[CTR_W-1:8]; ignored when CTR_W=8.
  - 2: reload — sets reload_req. In MMC3 modes, ctr is also cleared. In CPU-cycle mode, ctr<=latch immediately.
  - 3: en<=0 and pend<=0.
  - 4: en<=1.
  - 5..7: ignored.
- Input conditioning:
  - `m2` and `ppu_a12` each pass SYNC_ST flops.
  - A12 additionally passes a 2-sample deglitch: the output changes only after 2 equal consecutive samples.
  - m2_fall = one-clk pulse on a synchronised 1->0 transition.
- A12 qualification:
  - lowcnt increments, saturating at A12_FILT, on each m2_fall while deglitched A12=0.
  - lowcnt resets to 0 while A12=1.
  - a12_tick = deglitched 0->1 edge with lowcnt==A12_FILT.
- MMC3 / MMC3A, on a12_tick:
  - next = (ctr==0 | reload_req) ? latch : ctr-1; ctr<=next; reload_req<=0.
  - MMC3: pend<=1 if en & next==0.
  - MMC3A: pend<=1 if en & next==0 & (ctr!=0 | reload_req).
- CPU-cycle, on m2_fall with en=1:
  - ctr==0 → pend<=1 if en, then ctr<=latch.
  - otherwise ctr<=ctr-1.
  - Decrement arithmetic is CTR_W-bit modulo.
- Latency:
  - Pin edge to tick: SYNC_ST+2 clk.
  - Tick to irq: 1 clk (registered).
- Simultaneous events in one clk:
  - Register write beats tick: reload or latch write lands, and the tick is dropped.
  - Disable (reg 3) beats pend set.
  - Latch write plus tick in CPU-cycle mode: the new latch is used from the next reload.
- `mode` change: takes effect the next clk; ctr and pend unchanged.
- ss_act=1: ticks ignored, register writes ignored, irq holds its value.
- Reset asserted mid-count: all state clears immediately, irq drops asynchronously.

Optional Feature:
- Macro IRQ_CTR_SS_EN.
- When defined:
  - ss_dout = ss_addr 16 latch[7:0], 17 latch high byte, 18 {en}, 19 ctr[7:0], 20 ctr high byte, 21 {reload_req,pend}; else 8'hff.
  - An ss_we write at those addresses loads the field. It is only honoured with ss_act=1.
  - en (addr 18) must be restored before pend (addr 21).
- When undefined: ss_dout tied to 8'hff and ss_we ignored. Ports remain for a uniform interface.

Decomposition:
- Package irq_ctr_pkg holds:
  - mode encodings (MODE_MMC3, MODE_MMC3A, MODE_CPU);
  - register select constants (REG_LAT_LO..REG_EN);
  - save-state address constants (SS_IRQ_BASE=16 and offsets).
- Sub-module sig_cond: synchroniser + optional deglitch + rise/fall pulse outputs. Instanced for `m2` and `ppu_a12`.

Test Plan:
- MMC3, latch=3, reload, en, 5 qualified A12 rises → irq asserts SYNC_ST+3 clk after the 4th rise (ctr 3,2,1,0); reg 3 write clears irq next clk.
- MMC3 vs MMC3A, latch=0, reload, en, 2 rises → MMC3 irq on both; MMC3A irq on the first only.
- A12 rises with only 2 M2 falls low between them (A12_FILT=3) → no tick, ctr unchanged; a 1-clk A12 glitch → no tick.
- CPU-cycle, CTR_W=16, latch=16'h0102, reload, en → irq after 259 m2 falls; ctr reloads to 0x0102.
- Tick and reg 2 write in the same clk → ctr=0 and reload_req=1, tick dropped; disable and pend-set in the same clk → irq stays 0.
- IRQ_CTR_SS_EN: read 16..21 under ss_act, reset, write back in order → ctr/latch/en/pend restored, irq level identical; assert map_rst mid-count → irq=0 asynchronously.

Source files
------------

// File: rtl/irq_ctr_pkg.sv
// irq_ctr_pkg: shared encodings for the scanline / CPU-cycle IRQ counter
// Holds mode encodings, register selects, save-state addresses and a byte-merge helper.
package irq_ctr_pkg;

  typedef enum logic [1:0] {
    MODE_MMC3  = 2'd0,
    MODE_MMC3A = 2'd1,
    MODE_CPU   = 2'd2,
    MODE_RSV   = 2'd3
  } mode_e;

  localparam logic [2:0] REG_LAT_LO = 3'd0;
  localparam logic [2:0] REG_LAT_HI = 3'd1;
  localparam logic [2:0] REG_RELOAD = 3'd2;
  localparam logic [2:0] REG_DIS    = 3'd3;
  localparam logic [2:0] REG_EN     = 3'd4;

  localparam logic [7:0] SS_IRQ_BASE = 8'd16;
  localparam logic [7:0] SS_LAT_LO   = 8'd0;
  localparam logic [7:0] SS_LAT_HI   = 8'd1;
  localparam logic [7:0] SS_EN       = 8'd2;
  localparam logic [7:0] SS_CTR_LO   = 8'd3;
  localparam logic [7:0] SS_CTR_HI   = 8'd4;
  localparam logic [7:0] SS_FLAGS    = 8'd5;

  // Replace the low or high byte of a 16-bit value; callers truncate to CTR_W.
  function automatic logic [15:0] put_byte(input logic [15:0] v, input logic hi, input logic [7:0] b);
    return hi ? {b, v[7:0]} : {v[15:8], b};
  endfunction

endpackage

// File: rtl/irq_ctr_gen_sig_cond.sv
// sig_cond: synchroniser for an asynchronous pin with optional 2-sample deglitch and edge pulses
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset (clears to low level)
//   din  - asynchronous input pin
//   lvl  - conditioned level
//   rise - one-clk pulse on a conditioned 0->1 transition
//   fall - one-clk pulse on a conditioned 1->0 transition
module sig_cond
  import irq_ctr_pkg::*;
#(
  parameter int ST   = 2,
  parameter bit DEGL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [ST-1:0] sy;
  logic          lvl_d;

  always_ff @(posedge clk or posedge rst)
    if (rst) sy <= '0;
    else sy <= ST'({sy, din});

  generate
    if (DEGL) begin : g_dg
      logic prev, deg;
      // The level only moves once two consecutive samples agree.
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          prev <= 1'b0;
          deg  <= 1'b0;
        end else begin
          prev <= sy[ST-1];
          if (sy[ST-1] == prev) deg <= prev;
        end
      assign lvl = deg;
    end else begin : g_nd
      assign lvl = sy[ST-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst)
    if (rst) lvl_d <= 1'b0;
    else lvl_d <= lvl;

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

endmodule

// File: rtl/irq_ctr_gen.sv
// irq_ctr_gen: parametrised MMC3 / MMC3A / CPU-cycle IRQ counter, fully synchronous to clk
// Ports:
//   clk      - system clock
//   map_rst  - asynchronous active-high reset, deassertion synchronised internally
//   m2       - CPU M2, asynchronous
//   ppu_a12  - PPU A12, asynchronous
//   mode     - 0 MMC3, 1 MMC3A, 2 CPU-cycle, 3 frozen
//   reg_we/reg_sel/reg_dat - register write port
//   ss_act/ss_we/ss_addr/ss_din/ss_dout - save-state port
//   irq      - IRQ pending, active-high
// Optional save-state access is compiled in with macro IRQ_CTR_SS_EN;
// without it ss_dout reads 8'hff and ss_we is ignored.
module irq_ctr_gen
  import irq_ctr_pkg::*;
#(
  parameter int CTR_W    = 8,
  parameter int SYNC_ST  = 2,
  parameter int A12_FILT = 3
) (
  input  logic       clk,
  input  logic       map_rst,
  input  logic       m2,
  input  logic       ppu_a12,
  input  logic [1:0] mode,
  input  logic       reg_we,
  input  logic [2:0] reg_sel,
  input  logic [7:0] reg_dat,
  input  logic       ss_act,
  input  logic       ss_we,
  input  logic [7:0] ss_addr,
  input  logic [7:0] ss_din,
  output logic [7:0] ss_dout,
  output logic       irq
);

  localparam int LW = (A12_FILT > 0) ? $clog2(A12_FILT + 1) : 1;
  localparam logic [LW-1:0] FILT = LW'(A12_FILT);

  logic [1:0]       rst_q;
  logic             rst;
  logic             a12_lvl, a12_rise, m2_fall;
  logic             unused_a12_fall, unused_m2_lvl, unused_m2_rise;
  logic [LW-1:0]    lowcnt;
  logic [CTR_W-1:0] latch, ctr, lat_n, ctr_n, nxt;
  logic             en, pend, reload_req, en_n, pend_n, rr_n;
  logic             wr, cpu, mmc, lat_wr, drop, a12_tick, mmc_tick, cpu_tick, pend_set;

  // Reset asserts immediately and releases two clocks later.
  always_ff @(posedge clk or posedge map_rst)
    if (map_rst) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};

  assign rst = rst_q[1];

  sig_cond #(.ST(SYNC_ST), .DEGL(1'b0)) u_m2 (
    .clk (clk),
    .rst (rst),
    .din (m2),
    .lvl (unused_m2_lvl),
    .rise(unused_m2_rise),
    .fall(m2_fall)
  );

  sig_cond #(.ST(SYNC_ST), .DEGL(1'b1)) u_a12 (
    .clk (clk),
    .rst (rst),
    .din (ppu_a12),
    .lvl (a12_lvl),
    .rise(a12_rise),
    .fall(unused_a12_fall)
  );

  // Out of reset the filter behaves as if A12 had been low long enough.
  always_ff @(posedge clk or posedge rst)
    if (rst) lowcnt <= FILT;
    else if (a12_lvl) lowcnt <= '0;
    else if (m2_fall && lowcnt != FILT) lowcnt <= lowcnt + LW'(1);

  always_comb begin
    wr       = reg_we & ~ss_act;
    cpu      = mode == MODE_CPU;
    mmc      = (mode == MODE_MMC3) | (mode == MODE_MMC3A);
    lat_wr   = (reg_sel == REG_LAT_LO) | (reg_sel == REG_LAT_HI);
    // Register writes swallow a coincident tick, except a CPU-mode latch
    // write, which lets the cycle count and takes effect at the next reload.
    drop     = wr & ~(cpu & lat_wr);
    a12_tick = a12_rise & (lowcnt == FILT);
    mmc_tick = mmc & a12_tick & ~ss_act & ~drop;
    cpu_tick = cpu & m2_fall & en & ~ss_act & ~drop;
    nxt      = (ctr == '0 || reload_req) ? latch : ctr - CTR_W'(1);
    pend_set = (mmc_tick & en & (nxt == '0) & ((mode == MODE_MMC3) | (ctr != '0) | reload_req))
             | (cpu_tick & (ctr == '0));
    lat_n  = latch;
    ctr_n  = ctr;
    en_n   = en;
    pend_n = pend;
    rr_n   = reload_req;
    if (wr) begin
      if (lat_wr) lat_n = CTR_W'(put_byte(16'(latch), reg_sel == REG_LAT_HI, reg_dat));
      if (reg_sel == REG_RELOAD) begin
        rr_n  = 1'b1;
        ctr_n = cpu ? latch : '0;
      end
      if (reg_sel == REG_DIS) begin
        en_n   = 1'b0;
        pend_n = 1'b0;
      end
      if (reg_sel == REG_EN) en_n = 1'b1;
    end
    if (mmc_tick) begin
      ctr_n = nxt;
      rr_n  = 1'b0;
    end
    if (cpu_tick) ctr_n = (ctr == '0) ? latch : ctr - CTR_W'(1);
    if (pend_set) pend_n = 1'b1;
`ifdef IRQ_CTR_SS_EN
    if (ss_act & ss_we) begin
      if (ss_addr == SS_IRQ_BASE + SS_LAT_LO) lat_n = CTR_W'(put_byte(16'(latch), 1'b0, ss_din));
      if (ss_addr == SS_IRQ_BASE + SS_LAT_HI) lat_n = CTR_W'(put_byte(16'(latch), 1'b1, ss_din));
      if (ss_addr == SS_IRQ_BASE + SS_EN) en_n = ss_din[0];
      if (ss_addr == SS_IRQ_BASE + SS_CTR_LO) ctr_n = CTR_W'(put_byte(16'(ctr), 1'b0, ss_din));
      if (ss_addr == SS_IRQ_BASE + SS_CTR_HI) ctr_n = CTR_W'(put_byte(16'(ctr), 1'b1, ss_din));
      if (ss_addr == SS_IRQ_BASE + SS_FLAGS) begin
        rr_n   = ss_din[1];
        pend_n = ss_din[0];
      end
    end
`endif
  end

  // irq tracks pend but is held while a save-state session is open.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      latch      <= '0;
      ctr        <= '0;
      en         <= 1'b0;
      pend       <= 1'b0;
      reload_req <= 1'b0;
      irq        <= 1'b0;
    end else begin
      latch      <= lat_n;
      ctr        <= ctr_n;
      en         <= en_n;
      pend       <= pend_n;
      reload_req <= rr_n;
      irq        <= ss_act ? irq : pend_n;
    end

`ifdef IRQ_CTR_SS_EN
  logic [15:0] lat16, ctr16;
  logic [7:0]  ss_rd;

  always_comb begin
    lat16 = 16'(latch);
    ctr16 = 16'(ctr);
    ss_rd = (ss_addr == SS_IRQ_BASE + SS_LAT_LO) ? lat16[7:0]
          : (ss_addr == SS_IRQ_BASE + SS_LAT_HI) ? lat16[15:8]
          : (ss_addr == SS_IRQ_BASE + SS_EN)     ? {7'd0, en}
          : (ss_addr == SS_IRQ_BASE + SS_CTR_LO) ? ctr16[7:0]
          : (ss_addr == SS_IRQ_BASE + SS_CTR_HI) ? ctr16[15:8]
          : (ss_addr == SS_IRQ_BASE + SS_FLAGS)  ? {6'd0, reload_req, pend}
          : 8'hff;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) ss_dout <= 8'hff;
    else ss_dout <= ss_rd;
`else
  logic unused_ss;
  assign unused_ss = ^{ss_we, ss_addr, ss_din};
  assign ss_dout   = 8'hff;
`endif

endmodule

// File: tb/tb_irq_ctr_gen.sv
// tb_irq_ctr_gen: directed self-checking bench for irq_ctr_gen (CTR_W=16, SYNC_ST=2, A12_FILT=3)
module tb_irq_ctr_gen;

  logic       clk = 1'b0;
  logic       map_rst = 1'b1;
  logic       m2 = 1'b0;
  logic       ppu_a12 = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       reg_we = 1'b0;
  logic [2:0] reg_sel = 3'd0;
  logic [7:0] reg_dat = 8'd0;
  logic       ss_act = 1'b0;
  logic       ss_we = 1'b0;
  logic [7:0] ss_addr = 8'd0;
  logic [7:0] ss_din = 8'd0;
  logic [7:0] ss_dout;
  logic       irq;

  int checks = 0;
  int errors = 0;

  irq_ctr_gen #(.CTR_W(16), .SYNC_ST(2), .A12_FILT(3)) dut (
    .clk    (clk),
    .map_rst(map_rst),
    .m2     (m2),
    .ppu_a12(ppu_a12),
    .mode   (mode),
    .reg_we (reg_we),
    .reg_sel(reg_sel),
    .reg_dat(reg_dat),
    .ss_act (ss_act),
    .ss_we  (ss_we),
    .ss_addr(ss_addr),
    .ss_din (ss_din),
    .ss_dout(ss_dout),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  md;
    logic [15:0] lat;
    int          rises;
    logic        exp;
  } vec_t;

  vec_t tv[10];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] s, input logic [7:0] d);
    reg_sel = s;
    reg_dat = d;
    reg_we  = 1'b1;
    tick(1);
    reg_we  = 1'b0;
  endtask

  task automatic do_reset();
    map_rst = 1'b1;
    tick(2);
    map_rst = 1'b0;
    tick(4);
  endtask

  task automatic m2_cyc();
    m2 = 1'b1;
    tick(3);
    m2 = 1'b0;
    tick(3);
  endtask

  task automatic a12_rise(input int falls);
    ppu_a12 = 1'b0;
    tick(4);
    repeat (falls) m2_cyc();
    ppu_a12 = 1'b1;
    tick(6);
    ppu_a12 = 1'b0;
  endtask

  // Qualified A12 rise whose tick lands in the same clk as a register write.
  task automatic collide(input logic [2:0] s);
    ppu_a12 = 1'b0;
    tick(4);
    repeat (3) m2_cyc();
    ppu_a12 = 1'b1;
    tick(4);
    wr(s, 8'd0);
    tick(2);
    ppu_a12 = 1'b0;
  endtask

  task automatic setup(input logic [1:0] md, input logic [15:0] lat);
    do_reset();
    mode = md;
    wr(3'd0, lat[7:0]);
    wr(3'd1, lat[15:8]);
    wr(3'd2, 8'd0);
    wr(3'd4, 8'd0);
  endtask

  logic [7:0] ss_exp[6];
  logic [7:0] ss_sav[6];

  initial begin
    tv[0] = '{2'd0, 16'd3,     3, 1'b0};
    tv[1] = '{2'd0, 16'd3,     4, 1'b1};
    tv[2] = '{2'd0, 16'd1,     2, 1'b1};
    tv[3] = '{2'd1, 16'd0,     1, 1'b1};
    tv[4] = '{2'd1, 16'd2,     3, 1'b1};
    tv[5] = '{2'd3, 16'd0,     2, 1'b0};
    tv[6] = '{2'd0, 16'h0100,  2, 1'b0};
    tv[7] = '{2'd2, 16'd5,     2, 1'b1};
    tv[8] = '{2'd2, 16'd6,     2, 1'b0};
    tv[9] = '{2'd0, 16'd2,     0, 1'b0};
    ss_exp = '{8'h23, 8'h01, 8'h01, 8'h23, 8'h01, 8'h01};

    tick(3);
    chk("reset_irq", 16'(irq), 16'd0);
    chk("reset_ss_dout", 16'(ss_dout), 16'hff);
    map_rst = 1'b0;
    tick(4);

    for (int i = 0; i < 10; i++) begin
      setup(tv[i].md, tv[i].lat);
      repeat (tv[i].rises) a12_rise(3);
      tick(4);
      chk($sformatf("vec%0d_irq", i), 16'(irq), 16'(tv[i].exp));
      chk($sformatf("vec%0d_ss_dout", i), 16'(ss_dout), 16'hff);
    end

    // MMC3 latch=3: irq exactly SYNC_ST+3 clk after the 4th rise.
    setup(2'd0, 16'd3);
    repeat (3) a12_rise(3);
    ppu_a12 = 1'b0;
    tick(4);
    repeat (3) m2_cyc();
    ppu_a12 = 1'b1;
    tick(4);
    chk("lat_rise4_early", 16'(irq), 16'd0);
    tick(1);
    chk("lat_rise4_irq", 16'(irq), 16'd1);
    tick(1);
    a12_rise(3);
    tick(4);
    chk("lat_rise5_hold", 16'(irq), 16'd1);
    wr(3'd3, 8'd0);
    chk("lat_dis_clear", 16'(irq), 16'd0);

    // MMC3 vs MMC3A with latch=0.
    for (int m = 0; m < 2; m++) begin
      setup(2'(m), 16'd0);
      a12_rise(3);
      tick(4);
      chk($sformatf("zero_m%0d_r1", m), 16'(irq), 16'd1);
      wr(3'd3, 8'd0);
      wr(3'd4, 8'd0);
      chk($sformatf("zero_m%0d_clr", m), 16'(irq), 16'd0);
      a12_rise(3);
      tick(4);
      chk($sformatf("zero_m%0d_r2", m), 16'(irq), (m == 0) ? 16'd1 : 16'd0);
    end

    // A12 filter: short low period and 1-clk glitch must not clock.
    setup(2'd0, 16'd1);
    a12_rise(3);
    tick(4);
    chk("filt_first", 16'(irq), 16'd0);
    a12_rise(2);
    tick(4);
    chk("filt_short_low", 16'(irq), 16'd0);
    ppu_a12 = 1'b0;
    tick(4);
    repeat (3) m2_cyc();
    ppu_a12 = 1'b1;
    tick(1);
    ppu_a12 = 1'b0;
    tick(8);
    chk("filt_glitch", 16'(irq), 16'd0);
    a12_rise(3);
    tick(4);
    chk("filt_valid", 16'(irq), 16'd1);

    // CPU-cycle with a 16-bit latch of 0x0102: 259 falls per IRQ.
    setup(2'd2, 16'h0102);
    for (int r = 0; r < 2; r++) begin
      repeat (258) m2_cyc();
      chk($sformatf("cpu%0d_258", r), 16'(irq), 16'd0);
      m2_cyc();
      chk($sformatf("cpu%0d_259", r), 16'(irq), 16'd1);
      wr(3'd3, 8'd0);
      wr(3'd4, 8'd0);
    end

    // Reload write collides with tick: tick dropped, ctr cleared with reload pending.
    setup(2'd0, 16'd2);
    a12_rise(3);
    a12_rise(3);
    collide(3'd2);
    tick(2);
    chk("col_reload", 16'(irq), 16'd0);
    a12_rise(3);
    tick(4);
    chk("col_reload_r1", 16'(irq), 16'd0);
    a12_rise(3);
    tick(4);
    chk("col_reload_r2", 16'(irq), 16'd0);
    a12_rise(3);
    tick(4);
    chk("col_reload_r3", 16'(irq), 16'd1);

    // Disable collides with a tick that would set pend.
    setup(2'd0, 16'd0);
    collide(3'd3);
    tick(2);
    chk("col_dis", 16'(irq), 16'd0);
    wr(3'd4, 8'd0);
    tick(2);
    chk("col_dis_en", 16'(irq), 16'd0);
    a12_rise(3);
    tick(4);
    chk("col_dis_next", 16'(irq), 16'd1);

    // Asynchronous reset drops irq without a clock edge.
    setup(2'd0, 16'd0);
    a12_rise(3);
    tick(4);
    chk("async_pre", 16'(irq), 16'd1);
    @(posedge clk);
    #2 map_rst = 1'b1;
    #1 chk("async_rst", 16'(irq), 16'd0);
    tick(3);
    map_rst = 1'b0;
    tick(4);
    chk("async_post", 16'(irq), 16'd0);

`ifdef IRQ_CTR_SS_EN
    setup(2'd0, 16'd0);
    a12_rise(3);
    wr(3'd0, 8'h23);
    wr(3'd1, 8'h01);
    a12_rise(3);
    tick(4);
    chk("ss_pre_irq", 16'(irq), 16'd1);
    ss_act = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ss_addr = 8'(16 + k);
      tick(1);
      chk($sformatf("ss_rd%0d", 16 + k), 16'(ss_dout), 16'(ss_exp[k]));
      ss_sav[k] = ss_dout;
    end
    map_rst = 1'b1;
    tick(2);
    chk("ss_rst_irq", 16'(irq), 16'd0);
    map_rst = 1'b0;
    tick(4);
    for (int k = 0; k < 6; k++) begin
      ss_addr = 8'(16 + k);
      ss_din  = ss_sav[k];
      ss_we   = 1'b1;
      tick(1);
      ss_we   = 1'b0;
    end
    for (int k = 0; k < 6; k++) begin
      ss_addr = 8'(16 + k);
      tick(1);
      chk($sformatf("ss_back%0d", 16 + k), 16'(ss_dout), 16'(ss_exp[k]));
    end
    chk("ss_irq_frozen", 16'(irq), 16'd0);
    ss_act = 1'b0;
    tick(1);
    chk("ss_irq_restored", 16'(irq), 16'd1);
    a12_rise(3);
    ss_addr = 8'd19;
    tick(2);
    chk("ss_count_on", 16'(ss_dout), 16'h22);
    ss_addr = 8'd0;
`else
    ss_act  = 1'b1;
    ss_addr = 8'd18;
    ss_din  = 8'd0;
    ss_we   = 1'b1;
    tick(1);
    ss_we   = 1'b0;
    ss_act  = 1'b0;
    tick(2);
    chk("ss_off_dout", 16'(ss_dout), 16'hff);
    ss_addr = 8'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
